// File: rtl/pe_mac_tree.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_tree
// Description : LANES-wide multiply / registered adder tree / group
//               accumulator PE with dual-channel and unsigned-ifm modes.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_tree #(
  parameter int LANES = 32,
  parameter int IFM_W = 8,
  parameter int KER_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [1:0]             mode,
  input  logic [LANES*IFM_W-1:0] pe_ifm,
  input  logic [LANES*KER_W-1:0] pe_kernel,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       pe_ofm0,
  output logic [ACC_W-1:0]       pe_ofm1,
  output logic [1:0]             out_ovf,
  output logic                   busy
);

  localparam int TREE_LV = $clog2(LANES);
  localparam int P_W     = IFM_W + KER_W + 1;
  localparam int S_W     = P_W + TREE_LV;
  localparam int H_W     = KER_W / 2;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_DUAL   = 2'b01;
  localparam logic [1:0] M_UNS    = 2'b10;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 0: input capture plus input-side group tracking so later beats
  // of a group reuse the mode latched on its first beat.
  logic                   r_s0_v, r_s0_f, r_s0_l;
  logic [1:0]             r_s0_mode;
  logic [LANES*IFM_W-1:0] r_ifm;
  logic [LANES*KER_W-1:0] r_ker;
  logic                   r_in_open;
  logic [1:0]             r_in_mode;
  logic [1:0]             w_mode_norm;
  logic [1:0]             w_beat_mode;

  assign w_mode_norm = (mode == 2'b11) ? M_SINGLE : mode;
  assign w_beat_mode = (in_first || !r_in_open) ? w_mode_norm : r_in_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0_v    <= 1'b0;
      r_s0_f    <= 1'b0;
      r_s0_l    <= 1'b0;
      r_s0_mode <= M_SINGLE;
      r_ifm     <= '0;
      r_ker     <= '0;
      r_in_open <= 1'b0;
      r_in_mode <= M_SINGLE;
    end else begin
      r_s0_v    <= in_valid;
      r_s0_f    <= in_valid & in_first;
      r_s0_l    <= in_valid & in_last;
      r_s0_mode <= w_beat_mode;
      r_ifm     <= pe_ifm;
      r_ker     <= pe_kernel;
      if (in_valid) begin
        r_in_mode <= w_beat_mode;
        r_in_open <= !in_last;
      end
    end
  end

  // Stage 1 products (combinational part), sign-extended to tree width.
  logic signed [S_W-1:0] w_p0 [LANES];
  logic signed [S_W-1:0] w_p1 [LANES];

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_p0[j] = '0;
      w_p1[j] = '0;
      if (r_s0_mode == M_DUAL) begin
        w_p0[j] = S_W'(P_W'($signed(r_ker[j*KER_W +: H_W]))
                     * P_W'($signed(r_ifm[j*IFM_W +: IFM_W])));
        w_p1[j] = S_W'(P_W'($signed(r_ker[j*KER_W+H_W +: H_W]))
                     * P_W'($signed(r_ifm[j*IFM_W +: IFM_W])));
      end else begin
        w_p0[j] = S_W'(P_W'($signed(r_ker[j*KER_W +: KER_W]))
                     * P_W'($signed({(r_s0_mode != M_UNS) && r_ifm[j*IFM_W+IFM_W-1],
                                     r_ifm[j*IFM_W +: IFM_W]})));
      end
    end
  end

  // Level 0 holds the registered products; level l holds LANES>>l partial
  // sums. Storage is full tree width throughout, values are sign-extended.
  logic signed [S_W-1:0] r_t0 [TREE_LV+1][LANES];
  logic signed [S_W-1:0] r_t1 [TREE_LV+1][LANES];
  logic [TREE_LV:0]      r_v, r_f, r_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      r_f <= '0;
      r_l <= '0;
      for (int l = 0; l <= TREE_LV; l++) begin
        for (int j = 0; j < LANES; j++) begin
          r_t0[l][j] <= '0;
          r_t1[l][j] <= '0;
        end
      end
    end else begin
      r_v <= {r_v[TREE_LV-1:0], r_s0_v};
      r_f <= {r_f[TREE_LV-1:0], r_s0_f};
      r_l <= {r_l[TREE_LV-1:0], r_s0_l};
      for (int j = 0; j < LANES; j++) begin
        r_t0[0][j] <= w_p0[j];
        r_t1[0][j] <= w_p1[j];
      end
      for (int l = 1; l <= TREE_LV; l++) begin
        for (int j = 0; j < LANES/2; j++) begin
          if (j < (LANES >> l)) begin
            r_t0[l][j] <= r_t0[l-1][2*j] + r_t0[l-1][2*j+1];
            r_t1[l][j] <= r_t1[l-1][2*j] + r_t1[l-1][2*j+1];
          end
        end
      end
    end
  end

  // Accumulate stage: a first beat, or any beat with no group open,
  // starts from zero with cleared flags.
  logic                    r_open;
  logic signed [ACC_W-1:0] r_acc [2];
  logic [1:0]              r_ovf;
  logic                    w_fresh;
  logic signed [ACC_W-1:0] w_sum  [2];
  logic signed [ACC_W-1:0] w_base [2];
  logic        [ACC_W:0]   w_add  [2];
  logic signed [ACC_W-1:0] w_sat  [2];
  logic [1:0]              w_ov;

  assign w_fresh  = r_f[TREE_LV] | ~r_open;
  assign w_sum[0] = ACC_W'(r_t0[TREE_LV][0]);
  assign w_sum[1] = ACC_W'(r_t1[TREE_LV][0]);

  always_comb begin
    w_ov = 2'b00;
    for (int c = 0; c < 2; c++) begin
      w_base[c] = w_fresh ? '0 : r_acc[c];
      w_add[c]  = {w_base[c][ACC_W-1], w_base[c]} + {w_sum[c][ACC_W-1], w_sum[c]};
      w_sat[c]  = w_add[c][ACC_W-1:0];
      if (w_add[c][ACC_W] != w_add[c][ACC_W-1]) begin
        w_sat[c] = w_add[c][ACC_W] ? SAT_MIN : SAT_MAX;
        w_ov[c]  = 1'b1;
      end
      if (!w_fresh && r_ovf[c]) w_ov[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_open    <= 1'b0;
      r_acc[0]  <= '0;
      r_acc[1]  <= '0;
      r_ovf     <= 2'b00;
      out_valid <= 1'b0;
      pe_ofm0   <= '0;
      pe_ofm1   <= '0;
      out_ovf   <= 2'b00;
    end else begin
      out_valid <= 1'b0;
      if (r_v[TREE_LV]) begin
        r_acc[0] <= w_sat[0];
        r_acc[1] <= w_sat[1];
        if (r_l[TREE_LV]) begin
          out_valid <= 1'b1;
          pe_ofm0   <= w_sat[0];
          pe_ofm1   <= w_sat[1];
          out_ovf   <= w_ov;
          r_ovf     <= 2'b00;
          r_open    <= 1'b0;
        end else begin
          r_ovf  <= w_ov;
          r_open <= 1'b1;
        end
      end
    end
  end

  assign busy = r_s0_v | (|r_v) | r_open;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_tree
// Description : Scoreboard bench for pe_mac_tree with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_tree;

  localparam int LANES = 32;
  localparam int IFM_W = 8;
  localparam int KER_W = 16;
  localparam int ACC_W = 32;
  localparam int LAT   = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid, in_first, in_last;
  logic [1:0]             mode;
  logic [LANES*IFM_W-1:0] pe_ifm;
  logic [LANES*KER_W-1:0] pe_kernel;
  logic                   out_valid;
  logic [ACC_W-1:0]       pe_ofm0, pe_ofm1;
  logic [1:0]             out_ovf;
  logic                   busy;

  pe_mac_tree #(.LANES(LANES), .IFM_W(IFM_W), .KER_W(KER_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .mode(mode), .pe_ifm(pe_ifm), .pe_kernel(pe_kernel),
    .out_valid(out_valid), .pe_ofm0(pe_ofm0), .pe_ofm1(pe_ofm1),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic [1:0]  ov;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("ofm0", pe_ofm0, e.o0);
        check("ofm1", pe_ofm1, e.o1);
        check("ovf", {30'b0, out_ovf}, {30'b0, e.ov});
        check("latency", 32'(cyc), 32'(e.cyc + LAT));
      end
    end
  end

  task automatic beat(input logic f, input logic l, input logic [1:0] m,
                      input logic [7:0] ifm, input logic [15:0] ker);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_first  = f;
    in_last   = l;
    mode      = m;
    pe_ifm    = {LANES{ifm}};
    pe_kernel = {LANES{ker}};
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ov);
    exp_t e;
    e.o0  = e0;
    e.o1  = e1;
    e.ov  = ov;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    idle();
    while (sb.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mode = 2'b00; pe_ifm = '0; pe_kernel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ofm0", pe_ofm0, 32'd0);
    check("rst_ofm1", pe_ofm1, 32'd0);
    check("rst_ovf", {30'b0, out_ovf}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(); idle();

    // single beat, signed
    beat(1, 1, 2'b00, 8'd1, 16'd1);          push(32'd32, 32'd0, 2'b00);
    drain();
    // dual mode: lo=-1, hi=2, ifm=3
    beat(1, 1, 2'b01, 8'd3, 16'h02FF);       push(-32'sd96, 32'd192, 2'b00);
    drain();
    // unsigned vs signed ifm, back to back
    beat(1, 1, 2'b10, 8'hFF, 16'd1);         push(32'd8160, 32'd0, 2'b00);
    beat(1, 1, 2'b00, 8'hFF, 16'd1);         push(-32'sd32, 32'd0, 2'b00);
    drain();
    // four-beat group with bubble and mid-group mode change
    beat(1, 0, 2'b00, 8'd1, 16'd1);
    beat(0, 0, 2'b00, 8'd1, 16'd1);
    idle(); idle();
    check("busy_in_group", {31'b0, busy}, 32'd1);
    beat(0, 0, 2'b01, 8'd1, 16'd1);
    beat(0, 1, 2'b00, 8'd1, 16'd1);          push(32'd128, 32'd0, 2'b00);
    drain();
    // mode on a later beat must not switch the ifm to unsigned
    beat(1, 0, 2'b00, 8'hFF, 16'd1);
    beat(0, 1, 2'b10, 8'hFF, 16'd1);         push(-32'sd64, 32'd0, 2'b00);
    drain();
    // saturation over 17 beats of 2^27, then a clean group
    beat(1, 0, 2'b00, 8'h80, 16'h8000);
    for (int i = 0; i < 15; i++) beat(0, 0, 2'b00, 8'h80, 16'h8000);
    beat(0, 1, 2'b00, 8'h80, 16'h8000);      push(32'h7FFF_FFFF, 32'd0, 2'b01);
    beat(1, 1, 2'b00, 8'd1, 16'd1);          push(32'd32, 32'd0, 2'b00);
    drain();
    // a new first discards the open partial
    beat(1, 0, 2'b00, 8'd1, 16'd1);
    beat(1, 1, 2'b00, 8'd2, 16'd1);          push(32'd64, 32'd0, 2'b00);
    drain();
    // orphan last beat with no open group
    beat(0, 1, 2'b00, 8'd1, 16'd3);          push(32'd96, 32'd0, 2'b00);
    drain();
    // reset three cycles into a four-beat group
    beat(1, 0, 2'b00, 8'd1, 16'd1);
    beat(0, 0, 2'b00, 8'd1, 16'd1);
    beat(0, 0, 2'b00, 8'd1, 16'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_ofm0", pe_ofm0, 32'd0);
    check("mid_rst_ofm1", pe_ofm1, 32'd0);
    check("mid_rst_ovf", {30'b0, out_ovf}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    beat(1, 1, 2'b00, 8'd2, 16'd2);          push(32'd128, 32'd0, 2'b00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_mac_tree.md
Name: pe_mac_tree

Overview:
- Parametrised successor PE: LANES parallel multipliers (kernel x ifm), a fully registered binary adder tree, and a group accumulator that sums many input beats into one output.
- Adds valid/first/last framing, dual-channel split-kernel mode, unsigned-activation mode, saturating accumulation and overflow flags.
- Sits between the ifm/kernel buffers and the output-feature-map writeback.

Parameters:
- LANES, 32, number of multiply lanes; power of two, >=2; TREE_LV = log2(LANES) (localparam)
- IFM_W, 8, bits per ifm element
- KER_W, 16, bits per kernel element; must be even
- ACC_W, 32, accumulator/output width; must be >= IFM_W+KER_W+TREE_LV

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  beat qualifier
- in_first  input  1  first beat of group (sampled with in_valid)
- in_last  input  1  last beat of group (sampled with in_valid)
- mode  input  2  00 single signed; 01 dual signed; 10 single, unsigned ifm; 11 treated as 00
- pe_ifm  input  LANES*IFM_W  lane i = bits [i*IFM_W +: IFM_W]
- pe_kernel  input  LANES*KER_W  lane i = bits [i*KER_W +: KER_W]
- out_valid  output  1  one-cycle pulse, result valid
- pe_ofm0  output  ACC_W  channel-0 result (only result in single modes)
- pe_ofm1  output  ACC_W  channel-1 result (dual mode); 0 in single modes
- out_ovf  output  2  saturation flags for ofm1, ofm0 (bit1, bit0)
- busy  output  1  any valid beat in the pipeline or a group open

Behaviour:
- Reset (reset=0, async): all pipeline registers, valid bits, accumulators, out_valid, pe_ofm0/1, out_ovf and busy go to 0. No in-flight beat produces out_valid after release.
- Stage 0: register ifm, kernel, mode, valid, first and last.
- Stage 1 (multiply), per lane:
  - Single modes: p0 = kernel (signed) x ifm. The ifm is signed for modes 00/11 and zero-extended for mode 10. Width IFM_W+KER_W+1, sign-extended.
  - Dual mode: p0 = kernel[KER_W/2-1:0] x ifm; p1 = kernel[KER_W-1:KER_W/2] x ifm. All operands signed.
- Stages 2..TREE_LV+1 (adder tree): one registered tree level per stage, each level one bit wider, sign-extended. Two trees (ch0, ch1); ch1 is forced to 0 in single modes.
- Final stage (accumulate):
  - Tree sum is sign-extended to ACC_W.
  - first=1: acc <= sum, with no add.
  - Otherwise acc <= acc + sum, saturated to the signed ACC_W range; on saturation the channel ovf bit is set (sticky within the group).
  - A beat with first=0 when no group is open accumulates onto 0 and opens a group.
- Output: on a valid last beat, pe_ofm0/1 <= saturated acc values, out_ovf <= flags, out_valid=1 for one cycle. Group closes; flags clear.
  - pe_ofm0/1 and out_ovf hold their value until the next out_valid.
- Latency: in_valid of the last beat -> out_valid is TREE_LV+3 cycles (8 for LANES=32). Throughput is one beat per cycle with no stall.
- first and last together: single-beat group, result = that beat's sum.
- first while a group is open: the previous partial is discarded without output, and a new group starts.
- Mode is captured on the first beat of a group. mode on later beats of the same group is ignored.
- in_valid=0 cycles inside a group are bubbles; the accumulator holds.
- busy = OR of the stage valid bits, or the group-open flag.

Test Plan:
- Mode 00, LANES=32, all ifm=1, kernel=1, first=last=1 -> out_valid exactly 8 cycles later; pe_ofm0=32, pe_ofm1=0, out_ovf=0.
- Mode 01, all kernel={hi=2, lo=-1} (16'h02FF), ifm=3, single beat -> pe_ofm0=-96, pe_ofm1=192.
- ifm=8'hFF, kernel=1, single beat: mode 10 -> pe_ofm0=8160; mode 00 -> pe_ofm0=-32.
- Four back-to-back beats (first on beat 1, last on beat 4), each summing to 32, one 2-cycle bubble inside -> single out_valid with 128; mode change on beat 3 has no effect.
- 17 beats of kernel=-32768, ifm=-128 (each beat sum 2^27) -> pe_ofm0=2147483647, out_ovf=2'b01; the next group reports out_ovf=0.
- Assert reset 3 cycles into a 4-beat group -> all outputs 0 immediately; no out_valid after release. A fresh single-beat group then returns a correct result after 8 cycles.
